bcd_updown_counter: RTL and testbench
=====================================

BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 2, number of cascaded BCD digits (1..8).
REQ-002 SHALL have parameter WRAP, default 1; 1 = wrap at terminal count, 0 = saturate at terminal count.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; one step per clk while high.
REQ-006 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 SHALL have port clear  input  1  synchronous clear to zero.
REQ-008 SHALL have port load  input  1  synchronous parallel load.
REQ-009 SHALL have port load_val  input  4*DIGITS  BCD load value; digit i occupies bits [4i+3:4i].
REQ-010 SHALL have port count  output  4*DIGITS  registered BCD count; digit 0 is least significant.
REQ-011 SHALL have port tc  output  1  combinational terminal count.
REQ-012 SHALL have port ovf  output  1  registered one-cycle overflow/underflow pulse.

Function
REQ-013 Priority per clk edge SHALL be: clear > load > (en step) > hold.
REQ-014 clear=1 SHALL set count to all-zero digits and ovf to 0 on the next edge, regardless of load/en.
REQ-015 load=1 (clear=0) SHALL set each count digit to load_val digit, clamping any digit value 10..15 to 9; ovf SHALL be 0.
REQ-016 Up step SHALL increment digit 0; a digit at 9 SHALL go to 0 and carry into the next digit. Digit i SHALL change only when all lower digits are 9.
REQ-017 Down step SHALL decrement digit 0; a digit at 0 SHALL go to 9 and borrow from the next digit. Digit i SHALL change only when all lower digits are 0.
REQ-018 Terminal state SHALL be all digits 9 when up=1 and all digits 0 when up=0.
REQ-019 tc SHALL equal en AND (count is at the terminal state for the current up value), combinationally, with no clear/load gating.
REQ-020 With WRAP=1, an up step from all-9s SHALL yield all-0s. A down step from all-0s SHALL yield all-9s.
REQ-021 With WRAP=0, a step from the terminal state SHALL leave count unchanged.
REQ-022 ovf SHALL be 1 for exactly the one cycle after any en step taken from the terminal state, in either WRAP mode. Otherwise ovf SHALL be 0.
REQ-023 A change of up in the same cycle as a step SHALL use the new up value for both the step and tc; no pipeline delay.
REQ-024 en=0 with clear=0 and load=0 SHALL hold count and drive ovf to 0.
REQ-025 count digits SHALL never hold a value above 9 in any reachable state.

Reset
REQ-026 reset=0 SHALL asynchronously force count to all zeros and ovf to 0, independent of clk.
REQ-027 While reset=0, all inputs SHALL be ignored. The first step SHALL occur on the first rising clk edge after reset is released.
REQ-028 Reset asserted mid-count SHALL discard the count with no pending ovf pulse after release.

Verification (DIGITS=2 unless stated)
REQ-029 reset=0 then release, en=1, up=1, 100 clocks -> count 00,01..99,00. ovf=1 only in the cycle count shows 00 after 99. tc=1 only while count=99.
REQ-030 load=1, load_val=0x3F -> count=0x39. Then en=1, up=0 for 40 clocks -> count reaches 0x00 after 39 steps, then 0x99 with ovf pulse.
REQ-031 WRAP=0, count=0x98, en=1, up=1, 3 clocks -> 0x99, 0x99, 0x99. ovf pulses after 2nd and 3rd steps. tc stays 1.
REQ-032 clear=1, load=1 and en=1 in the same cycle with count=0x57 -> count=0x00, ovf=0. Then load=1 alone with 0x42 -> 0x42.
REQ-033 count=0x10, en=1, up=0 -> 0x09. Toggle up=1 next cycle -> 0x10, no ovf.
REQ-034 Assert reset asynchronously between edges at count=0x63 -> count=0x00 immediately. Release -> counting resumes from 0x00.

Source files
------------

// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with clear, clamped parallel load, wrap or saturate at terminal count.
// Latency: count and ovf are registered (1 cycle); tc is combinational from count, en and up.
// Backpressure: none; one step is taken on every clk edge while en is high.
`timescale 1ns/1ps
module bcd_updown_counter #(
    parameter int DIGITS = 2,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic                  ovf
);

    localparam int W = 4 * DIGITS;

    logic         all9;
    logic         all0;
    logic         at_term;
    logic [W-1:0] stepped;
    logic [W-1:0] clamped;
    logic [W-1:0] count_nxt;
    logic         ovf_nxt;

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (count[4*i +: 4] != 4'd0) all0 = 1'b0;
        end
    end

    assign at_term = up ? all9 : all0;
    assign tc      = en & at_term;

    // Ripple the carry/borrow: a digit moves only while every lower digit rolled over.
    always_comb begin
        logic       carry;
        logic [3:0] d;
        carry   = 1'b1;
        d       = 4'd0;
        stepped = count;
        for (int i = 0; i < DIGITS; i++) begin
            d = count[4*i +: 4];
            if (carry) begin
                if (up) begin
                    stepped[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
                    carry             = (d == 4'd9);
                end else begin
                    stepped[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
                    carry             = (d == 4'd0);
                end
            end
        end
    end

    always_comb begin
        clamped = load_val;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) clamped[4*i +: 4] = 4'd9;
        end
    end

    always_comb begin
        count_nxt = count;
        ovf_nxt   = 1'b0;
        if (clear) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = clamped;
        end else if (en) begin
            ovf_nxt = at_term;
            if (!at_term || (WRAP != 0)) count_nxt = stepped;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter: one wrapping and one saturating instance share stimulus.
`timescale 1ns/1ps
module tb_bcd_updown_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       clear;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count_w;
    logic [7:0] count_s;
    logic       tc_w;
    logic       tc_s;
    logic       ovf_w;
    logic       ovf_s;

    int total = 0;
    int bad   = 0;

    bcd_updown_counter #(.DIGITS(2), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(count_w), .tc(tc_w), .ovf(ovf_w)
    );

    bcd_updown_counter #(.DIGITS(2), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .clear(clear), .load(load),
        .load_val(load_val), .count(count_s), .tc(tc_s), .ovf(ovf_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 8'h00;
        #12;
        chk("rst_cnt", int'(count_w), 0);
        chk("rst_ovf", int'(ovf_w), 0);

        // Full up sweep 00..99..00 on the wrapping instance
        reset = 1'b1; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 100; i++) begin
            chk("up_tc", int'(tc_w), (i == 99) ? 1 : 0);
            tick;
            chk("up_cnt", int'(count_w), bcd((i + 1) % 100));
            chk("up_ovf", int'(ovf_w), (i == 99) ? 1 : 0);
        end

        // Clamped load, then count down through 00 to 99
        en = 1'b0; load = 1'b1; load_val = 8'h3F;
        tick;
        chk("ld_3f", int'(count_w), 'h39);
        chk("ld_ovf", int'(ovf_w), 0);
        load = 1'b0; en = 1'b1; up = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            chk("dn_cnt", int'(count_w), (k <= 39) ? bcd(39 - k) : 'h99);
            chk("dn_ovf", int'(ovf_w), (k == 40) ? 1 : 0);
            if (k == 39) chk("dn_tc", int'(tc_w), 1);
        end
        chk("sat_dn_cnt", int'(count_s), 'h00);
        chk("sat_dn_ovf", int'(ovf_s), 1);
        en = 1'b0;
        tick;
        chk("hold_cnt", int'(count_w), 'h99);
        chk("hold_ovf", int'(ovf_w), 0);

        // Saturate vs wrap from 98 upward
        load = 1'b1; load_val = 8'h98;
        tick;
        load = 1'b0; en = 1'b1; up = 1'b1;
        chk("sat_tc0", int'(tc_s), 0);
        tick;
        chk("sat_c1", int'(count_s), 'h99); chk("sat_o1", int'(ovf_s), 0); chk("sat_t1", int'(tc_s), 1);
        chk("wr_c1", int'(count_w), 'h99);
        tick;
        chk("sat_c2", int'(count_s), 'h99); chk("sat_o2", int'(ovf_s), 1); chk("sat_t2", int'(tc_s), 1);
        chk("wr_c2", int'(count_w), 'h00); chk("wr_o2", int'(ovf_w), 1);
        tick;
        chk("sat_c3", int'(count_s), 'h99); chk("sat_o3", int'(ovf_s), 1); chk("sat_t3", int'(tc_s), 1);
        chk("wr_c3", int'(count_w), 'h01); chk("wr_o3", int'(ovf_w), 0);
        en = 1'b0;
        #1;
        chk("tc_en_gate", int'(tc_s), 0);

        // Clear beats load and en, even at terminal count
        load = 1'b1; load_val = 8'h57;
        tick;
        chk("ld_57", int'(count_w), 'h57);
        clear = 1'b1; load = 1'b1; en = 1'b1; load_val = 8'h99;
        tick;
        chk("clr_cnt", int'(count_w), 'h00);
        chk("clr_ovf", int'(ovf_w), 0);
        chk("clr_sat_cnt", int'(count_s), 'h00);
        clear = 1'b0; en = 1'b0; load_val = 8'h42;
        tick;
        chk("ld_42", int'(count_w), 'h42);
        load_val = 8'hA5;
        tick;
        chk("ld_a5", int'(count_w), 'h95);

        // Borrow across digits, then direction flip
        load_val = 8'h10;
        tick;
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick;
        chk("bor_cnt", int'(count_w), 'h09);
        chk("bor_ovf", int'(ovf_w), 0);
        up = 1'b1;
        tick;
        chk("flip_cnt", int'(count_w), 'h10);
        chk("flip_ovf", int'(ovf_w), 0);

        // tc follows up combinationally
        en = 1'b0; clear = 1'b1;
        tick;
        clear = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        chk("tc_dn_00", int'(tc_w), 1);
        up = 1'b1;
        #1;
        chk("tc_up_00", int'(tc_w), 0);

        // Reset during a pending overflow pulse
        en = 1'b0; load = 1'b1; load_val = 8'h99;
        tick;
        load = 1'b0; en = 1'b1; up = 1'b1;
        tick;
        chk("pre_rst_ovf", int'(ovf_w), 1);
        #3 reset = 1'b0;
        #1;
        chk("arst_ovf", int'(ovf_w), 0);
        chk("arst_cnt0", int'(count_w), 'h00);
        #1 reset = 1'b1;
        en = 1'b0;
        tick;
        chk("post_rst_ovf", int'(ovf_w), 0);

        // Async reset mid-count at 63; inputs ignored while held
        load = 1'b1; load_val = 8'h63;
        tick;
        load = 1'b0; en = 1'b1; up = 1'b1;
        #3 reset = 1'b0;
        #1;
        chk("arst_cnt", int'(count_w), 'h00);
        load = 1'b1; load_val = 8'h55;
        tick;
        chk("rst_hold_cnt", int'(count_w), 'h00);
        chk("rst_hold_ovf", int'(ovf_w), 0);
        load = 1'b0; reset = 1'b1;
        tick;
        chk("resume1", int'(count_w), 'h01);
        tick;
        chk("resume2", int'(count_w), 'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
